// File: rtl/rle_chan_sched.sv
// rle_chan_sched: round-robin scheduler that shares one RLE encoder among NCH
// byte-stream channel FIFOs. A channel holds the encoder for a whole stream;
// its FIFO is muxed onto the encoder input, the end-of-stream flush is
// sequenced here, and every encoded word leaves tagged with the channel ID.
module rle_chan_sched #(
    parameter int NCH     = 4,
    parameter int CW      = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      ch_recv_ready,
    input  logic [NCH-1:0]      ch_eos,
    input  logic [8*NCH-1:0]    ch_data,
    output logic [NCH-1:0]      ch_rd_req,
    input  logic                enc_rd_req,
    input  logic                enc_wr_req,
    input  logic [23:0]         enc_out_data,
    output logic                enc_recv_ready,
    output logic                enc_send_ready,
    output logic [7:0]          enc_in_data,
    output logic                enc_eos,
    input  logic                out_send_ready,
    output logic                out_wr_req,
    output logic [24+CW-1:0]    out_data,
    output logic [CW-1:0]       grant_id,
    output logic                busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARB     = 3'd1;
    localparam logic [2:0] S_GRANT   = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    localparam logic [15:0]   CNT_MAX   = 16'hFFFF;
    localparam logic [15:0]   TO_VAL    = 16'(TIMEOUT);
    localparam logic          TO_EN     = (TIMEOUT != 0);
    localparam logic [CW-1:0] LAST_INIT = CW'(NCH - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] grant_q, grant_d;
    logic [CW-1:0] last_q, last_d;
    logic [15:0]   starve_q, starve_d;
    logic [15:0]   bytes_q, bytes_d;
    logic          armed_q, armed_d;
    logic          rel_q, rel_d;

    logic [NCH-1:0][7:0] ch_bytes;
    logic                in_grant;
    logic                g_ready;
    logic                g_eos;
    logic                rd_fire;
    logic                starving;
    logic                timeout_hit;
    logic                flush_ok;
    logic                arb_hit;
    logic [CW-1:0]       arb_id;
    logic [CW-1:0]       arb_cand;

    assign ch_bytes = ch_data;

    // Granted-channel views used by both the datapath and the FSM.
    assign in_grant    = (state_q == S_GRANT);
    assign g_ready     = ch_recv_ready[grant_q];
    assign g_eos       = ch_eos[grant_q];
    // One read per encoder request: rd_armed blocks a second strobe while
    // enc_rd_req is still high in the cycle after the read.
    assign rd_fire     = in_grant & enc_rd_req & g_ready & armed_q;
    // Encoder is waiting in REQUEST_INPUT with nothing to give it.
    assign starving    = enc_rd_req & ~g_ready;
    assign timeout_hit = TO_EN & (starve_q == TO_VAL);
    // Flushing is only legal with the encoder idle in REQUEST_INPUT and a
    // non-zero run behind it, otherwise the encoder would emit a zero count.
    assign flush_ok    = starving & (bytes_q != 16'd0) & (g_eos | timeout_hit);

    // Combinational datapath: no added latency between FIFO, encoder and output.
    assign enc_in_data    = ch_bytes[grant_q];
    assign out_data       = {grant_q, enc_out_data};
    assign busy           = (state_q != S_IDLE);
    assign out_wr_req     = enc_wr_req & busy;
    assign enc_send_ready = out_send_ready & busy;
    assign enc_recv_ready = in_grant & g_ready;
    assign enc_eos        = (state_q == S_DRAIN) | (state_q == S_RELEASE);
    assign grant_id       = grant_q;

    // Read strobe goes only to the granted channel.
    always_comb begin
        ch_rd_req = '0;
        if (rd_fire) begin
            ch_rd_req[grant_q] = 1'b1;
        end
    end

    // Round-robin pick: first ready channel after last_grant, wrapping mod NCH.
    // Scanning from the far end lets the nearest candidate overwrite the rest.
    always_comb begin
        arb_hit  = 1'b0;
        arb_id   = last_q;
        arb_cand = last_q;
        for (int k = NCH; k >= 1; k--) begin
            arb_cand = CW'((int'(last_q) + k) % NCH);
            if (ch_recv_ready[arb_cand]) begin
                arb_hit = 1'b1;
                arb_id  = arb_cand;
            end
        end
    end

    // Next-state logic: FSM, grant bookkeeping, read arming and counters.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        starve_d = starve_q;
        bytes_d  = bytes_q;
        armed_d  = armed_q;
        rel_d    = rel_q;

        if (rd_fire) begin
            armed_d = 1'b0;
        end else if (!enc_rd_req) begin
            armed_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (|ch_recv_ready) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                bytes_d  = 16'd0;
                starve_d = 16'd0;
                if (arb_hit) begin
                    grant_d = arb_id;
                    state_d = S_GRANT;
                end else begin
                    // Requester withdrew before the pick; nothing to grant.
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                if (rd_fire) begin
                    starve_d = 16'd0;
                    if (bytes_q != CNT_MAX) begin
                        bytes_d = bytes_q + 16'd1;
                    end
                end else if (starving && starve_q != CNT_MAX) begin
                    starve_d = starve_q + 16'd1;
                end
                if (flush_ok) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The first write seen here is the encoder's final flush word.
                if (out_wr_req) begin
                    rel_d   = 1'b0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // Two cycles of eos walk the encoder through RESET_COUNT -> INIT.
                if (rel_q) begin
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end else begin
                    rel_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            last_q   <= LAST_INIT;
            starve_q <= 16'd0;
            bytes_q  <= 16'd0;
            armed_q  <= 1'b1;
            rel_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            starve_q <= starve_d;
            bytes_q  <= bytes_d;
            armed_q  <= armed_d;
            rel_q    <= rel_d;
        end
    end

endmodule

// File: tb/tb_rle_chan_sched.sv
// Bench for rle_chan_sched: behavioural channel FIFOs and a bit-serial RLE
// encoder model (LSB first, {bit, 23-bit count}) surround the scheduler.
// Expected words go into a scoreboard queue; a negedge monitor pops them.
module tb_rle_chan_sched;

    localparam logic [2:0] E_INIT = 3'd0;
    localparam logic [2:0] E_REQ  = 3'd1;
    localparam logic [2:0] E_PROC = 3'd2;
    localparam logic [2:0] E_WR   = 3'd3;
    localparam logic [2:0] E_FL   = 3'd4;
    localparam logic [2:0] E_RC   = 3'd5;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      ch_rr;
    logic [3:0]      ch_eos_v;
    logic [3:0][7:0] ch_dat;
    logic [3:0]      ch_rd_req;
    logic            enc_rd_req, enc_wr_req;
    logic [23:0]     enc_out_data;
    logic            enc_recv_ready, enc_send_ready, enc_eos;
    logic [7:0]      enc_in_data;
    logic            out_send_ready, out_wr_req;
    logic [25:0]     out_data;
    logic [1:0]      grant_id;
    logic            busy;

    // encoder model state
    logic [2:0]  e_st;
    logic [22:0] e_cnt;
    logic        e_cur;
    logic [7:0]  e_byte;
    logic [2:0]  e_bi;

    // channel FIFOs
    logic [7:0] fmem [4][8];
    int         fcnt [4];

    logic [25:0] sb[$];
    int chk = 0;
    int err = 0;
    int wr_count = 0;
    int exp_total = 0;

    always #5 clk = ~clk;

    assign enc_rd_req   = (e_st == E_REQ);
    assign enc_wr_req   = ((e_st == E_WR) || (e_st == E_FL)) && enc_send_ready;
    assign enc_out_data = {e_cur, e_cnt};

    rle_chan_sched #(.NCH(4), .CW(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .ch_recv_ready(ch_rr), .ch_eos(ch_eos_v), .ch_data(ch_dat), .ch_rd_req(ch_rd_req),
        .enc_rd_req(enc_rd_req), .enc_wr_req(enc_wr_req), .enc_out_data(enc_out_data),
        .enc_recv_ready(enc_recv_ready), .enc_send_ready(enc_send_ready),
        .enc_in_data(enc_in_data), .enc_eos(enc_eos),
        .out_send_ready(out_send_ready), .out_wr_req(out_wr_req), .out_data(out_data),
        .grant_id(grant_id), .busy(busy)
    );

    function automatic logic [25:0] w(input int id, input logic b, input int n);
        return {2'(id), b, 23'(n)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_ch();
        for (int i = 0; i < 4; i++) begin
            ch_rr[i]  = (fcnt[i] != 0);
            ch_dat[i] = (fcnt[i] != 0) ? fmem[i][0] : 8'h00;
        end
    endtask

    task automatic push(input int ch, input logic [7:0] b);
        fmem[ch][fcnt[ch]] = b;
        fcnt[ch]++;
        drive_ch();
    endtask

    task automatic expect_word(input logic [25:0] x);
        sb.push_back(x);
        exp_total++;
    endtask

    // One clock of the environment: sample DUT outputs at negedge, then
    // advance the encoder model and FIFOs just after the posedge.
    task automatic step();
        logic [3:0] s_rd;
        logic       s_rr, s_eos, s_sr, b;
        logic [7:0] s_din;
        @(negedge clk);
        s_rd = ch_rd_req; s_rr = enc_recv_ready; s_din = enc_in_data;
        s_eos = enc_eos;  s_sr = enc_send_ready;
        @(posedge clk);
        #1;
        if (!rst) begin
            e_st = E_INIT; e_cnt = '0; e_cur = 1'b0;
        end else begin
            case (e_st)
                E_INIT: e_st = E_REQ;
                E_REQ: begin
                    if (s_rr) begin
                        e_byte = s_din; e_bi = 3'd0; e_st = E_PROC;
                    end else if (s_eos && e_cnt != 0) begin
                        e_st = E_FL;
                    end
                end
                E_PROC: begin
                    b = e_byte[e_bi];
                    if (e_cnt == 0 || b == e_cur) begin
                        if (e_cnt == 0) e_cur = b;
                        e_cnt = e_cnt + 23'd1;
                        if (e_bi == 3'd7) e_st = E_REQ;
                        else e_bi = e_bi + 3'd1;
                    end else begin
                        e_st = E_WR;
                    end
                end
                E_WR: if (s_sr) begin e_cnt = '0; e_st = E_PROC; end
                E_FL: if (s_sr) begin e_cnt = '0; e_st = E_RC; end
                default: e_st = E_INIT;
            endcase
        end
        for (int i = 0; i < 4; i++) begin
            if (s_rd[i] && fcnt[i] > 0) begin
                for (int j = 0; j < 7; j++) fmem[i][j] = fmem[i][j+1];
                fcnt[i]--;
            end
        end
        drive_ch();
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!(busy == 1'b0 && sb.size() == 0 &&
                 (fcnt[0] + fcnt[1] + fcnt[2] + fcnt[3]) == 0) && n < budget) begin
            step();
            n++;
        end
        chk++;
        if (n >= budget) begin
            err++;
            $display("FAIL %s: not idle after %0d cycles, pending words %0d", name, n, sb.size());
        end
    endtask

    // Scoreboard monitor and invariants, sampled at negedge.
    initial begin : mon
        logic [25:0] exp_w;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && out_wr_req === 1'b1) begin
                wr_count++;
                chk++;
                if (sb.size() == 0) begin
                    err++;
                    $display("FAIL out_word: got %h, required none", out_data);
                end else begin
                    exp_w = sb.pop_front();
                    if (out_data !== exp_w) begin
                        err++;
                        $display("FAIL out_word: got %h required %h", out_data, exp_w);
                    end
                end
            end
            if (rst === 1'b1 && ch_rd_req != 4'b0) begin
                chk++;
                if (ch_rd_req !== (4'b1 << grant_id) || enc_recv_ready !== 1'b1) begin
                    err++;
                    $display("FAIL rd_strobe: got %b grant %0d required one-hot on grant", ch_rd_req, grant_id);
                end
            end
            if (rst === 1'b1 && enc_eos === 1'b1 && e_st == E_REQ) begin
                chk++;
                if (e_cnt == 0) begin
                    err++;
                    $display("FAIL eos_zero_count: got count 0 required nonzero");
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        rst = 1'b0; out_send_ready = 1'b1; ch_eos_v = 4'b0;
        e_st = E_INIT; e_cnt = '0; e_cur = 1'b0; e_byte = 8'h00; e_bi = 3'd0;
        for (int i = 0; i < 4; i++) fcnt[i] = 0;
        drive_ch();

        // reset state, with round-robin traffic already queued
        push(0, 8'hFF); push(2, 8'hFF); push(3, 8'hFF);
        ch_eos_v = 4'b1101;
        expect_word(w(0, 1'b1, 8)); expect_word(w(2, 1'b1, 8)); expect_word(w(3, 1'b1, 8));
        repeat (3) step();
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_grant",    32'(grant_id), 32'd0);
        check("rst_rd_req",   32'(ch_rd_req), 32'd0);
        check("rst_wr",       32'(out_wr_req), 32'd0);
        check("rst_eos",      32'(enc_eos), 32'd0);
        check("rst_recv_rdy", 32'(enc_recv_ready), 32'd0);
        check("rst_send_rdy", 32'(enc_send_ready), 32'd0);
        rst = 1'b1;
        wait_idle("round_robin", 300);
        ch_eos_v = 4'b0;

        // single stream on ch1
        push(1, 8'h0F); ch_eos_v[1] = 1'b1;
        expect_word(w(1, 1'b1, 4)); expect_word(w(1, 1'b0, 4));
        n = 0;
        while (fcnt[1] != 0 && n < 50) begin step(); n++; end
        check("single_grant", 32'(grant_id), 32'd1);
        wait_idle("single", 200);
        check("single_busy", 32'(busy), 32'd0);
        ch_eos_v = 4'b0;

        // back-pressure during drain
        out_send_ready = 1'b0;
        push(3, 8'hFF); ch_eos_v[3] = 1'b1;
        expect_word(w(3, 1'b1, 8));
        n = 0;
        while (enc_eos !== 1'b1 && n < 100) begin step(); n++; end
        check("bp_reach_drain", 32'(enc_eos), 32'd1);
        base = wr_count;
        repeat (20) step();
        check("bp_no_write", 32'(wr_count), 32'(base));
        check("bp_hold_busy", 32'(busy), 32'd1);
        out_send_ready = 1'b1;
        wait_idle("bp", 100);
        check("bp_once", 32'(wr_count), 32'(base + 1));
        ch_eos_v = 4'b0;

        // starvation timeout on ch2, no eos
        push(2, 8'h00);
        expect_word(w(2, 1'b0, 8));
        n = 0;
        while (fcnt[2] != 0 && n < 50) begin step(); n++; end
        base = wr_count; n = 0;
        while (wr_count == base && n < 100) begin step(); n++; end
        chk++;
        if (n < 18 || n > 34) begin
            err++;
            $display("FAIL starve_delay: got %0d cycles required 18..34", n);
        end
        wait_idle("starve", 100);

        // late eos: asserted with two bytes still queued
        push(0, 8'hF0); push(0, 8'hFF); push(0, 8'h0F);
        expect_word(w(0, 1'b0, 4)); expect_word(w(0, 1'b1, 16)); expect_word(w(0, 1'b0, 4));
        n = 0;
        while (fcnt[0] != 2 && n < 50) begin step(); n++; end
        ch_eos_v[0] = 1'b1;
        wait_idle("late_eos", 300);
        ch_eos_v = 4'b0;

        // reset in the middle of a grant
        push(1, 8'hFF); push(1, 8'hFF); push(1, 8'hFF); push(1, 8'hFF);
        n = 0;
        while (fcnt[1] != 3 && n < 50) begin step(); n++; end
        check("midrst_pre_grant", 32'(grant_id), 32'd1);
        check("midrst_pre_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        step();
        check("midrst_busy",  32'(busy), 32'd0);
        check("midrst_rd",    32'(ch_rd_req), 32'd0);
        check("midrst_wr",    32'(out_wr_req), 32'd0);
        check("midrst_grant", 32'(grant_id), 32'd0);
        fcnt[1] = 0;
        drive_ch();
        rst = 1'b1;
        repeat (5) step();
        check("midrst_stay_idle", 32'(busy), 32'd0);

        check("total_writes", 32'(wr_count), 32'(exp_total));
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

endmodule
